// File: rtl/tia_fb_pkg.sv
// Shared constants and encodings for the TIA framebuffer arbiter.
package tia_fb_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 240;
  localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DONE
  } clr_state_e;

  typedef enum logic [1:0] {
    G_NONE,
    G_READ,
    G_WRITE,
    G_CLEAR
  } gnt_sel_e;

endpackage

// File: rtl/tia_fb_wfifo.sv
// Small synchronous FIFO holding queued pixel writes; push while full is
// legal when a pop happens in the same cycle.
module tia_fb_wfifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = store[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tia_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads first, then buffered pixel
// writes, then a sequenced full-framebuffer clear.
module tia_fb_arbiter #(
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 16,
  parameter int FB_WORDS   = tia_fb_pkg::FB_WORDS,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          pix_wr_i,
  input  logic [ADDR_WIDTH-1:0]         pix_addr_i,
  input  logic [DATA_WIDTH-1:0]         pix_dat_i,
  input  logic                          rd_req_i,
  input  logic [ADDR_WIDTH-1:0]         rd_addr_i,
  output logic                          rd_valid_o,
  output logic [DATA_WIDTH-1:0]         rd_dat_o,
  input  logic                          clear_i,
  input  logic [DATA_WIDTH-1:0]         clear_color_i,
  output logic                          clear_busy_o,
  output logic                          clear_done_o,
  output logic                          mem_en_o,
  output logic                          mem_we_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_dat_o,
  input  logic [DATA_WIDTH-1:0]         mem_dat_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [CNT_WIDTH-1:0]          ovf_cnt_o,
  output logic [CNT_WIDTH-1:0]          oor_cnt_o
);

  import tia_fb_pkg::*;

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  clr_state_e            state_q;
  clr_state_e            state_d;
  gnt_sel_e              gnt;
  logic [DATA_WIDTH-1:0] clr_color_q;
  logic [ADDR_WIDTH-1:0] clr_addr_q;
  logic                  rd_pend_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [EW-1:0]         fifo_rdata;
  logic [ADDR_WIDTH-1:0] fifo_addr;
  logic [DATA_WIDTH-1:0] fifo_dat;
  logic                  pop;
  logic                  push;
  logic                  pix_oor;
  logic                  ovf_evt;
  logic                  oor_evt;

  assign fifo_addr = fifo_rdata[EW-1:DATA_WIDTH];
  assign fifo_dat  = fifo_rdata[DATA_WIDTH-1:0];

  // Out-of-range is checked before fullness, so a pixel drops for one reason only.
  assign pix_oor = (pix_addr_i >= ADDR_WIDTH'(FB_WORDS));
  assign pop     = (gnt == G_WRITE);
  assign push    = pix_wr_i && !pix_oor && (!fifo_full || pop);
  assign ovf_evt = pix_wr_i && !pix_oor && fifo_full && !pop;
  assign oor_evt = pix_wr_i && pix_oor;

  tia_fb_wfifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_wfifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .wdata ({pix_addr_i, pix_dat_i}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level_o)
  );

  always_comb begin
    gnt = G_NONE;
    if (rd_req_i)               gnt = G_READ;
    else if (!fifo_empty)       gnt = G_WRITE;
    else if (state_q == S_CLEAR) gnt = G_CLEAR;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clear_i) state_d = S_CLEAR;
      S_CLEAR: if (gnt == G_CLEAR && clr_addr_q == ADDR_WIDTH'(FB_WORDS - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    clear_busy_o = (state_q == S_CLEAR);
    clear_done_o = (state_q == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clr_color_q <= '0;
      clr_addr_q  <= '0;
    end else if (state_q == S_IDLE && clear_i) begin
      clr_color_q <= clear_color_i;
      clr_addr_q  <= '0;
    end else if (gnt == G_CLEAR) begin
      clr_addr_q  <= clr_addr_q + 1'b1;
    end
  end

  // The grant chosen this cycle becomes the RAM command next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_en_o   <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_dat_o  <= '0;
    end else begin
      mem_en_o <= (gnt != G_NONE);
      mem_we_o <= (gnt == G_WRITE) || (gnt == G_CLEAR);
      case (gnt)
        G_READ:  mem_addr_o <= rd_addr_i;
        G_WRITE: begin
          mem_addr_o <= fifo_addr;
          mem_dat_o  <= fifo_dat;
        end
        G_CLEAR: begin
          mem_addr_o <= clr_addr_q;
          mem_dat_o  <= clr_color_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend_q  <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_dat_o   <= '0;
    end else begin
      rd_pend_q  <= mem_en_o && !mem_we_o;
      rd_valid_o <= rd_pend_q;
      if (rd_pend_q) rd_dat_o <= mem_dat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_cnt_o <= '0;
      oor_cnt_o <= '0;
    end else begin
      if (ovf_evt && ovf_cnt_o != '1) ovf_cnt_o <= ovf_cnt_o + 1'b1;
      if (oor_evt && oor_cnt_o != '1) oor_cnt_o <= oor_cnt_o + 1'b1;
    end
  end

endmodule
